// File: rtl/lsu.sv
// lsu: load/store unit for the rv32i execute stage.
// Checks alignment of the ALU-computed effective address, issues a single
// outstanding request on a req/ack data-memory port, and returns extended load
// data or performs a byte-lane-masked store. busy stays high until the cycle
// after done so the pipeline stalls for the whole operation.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_req_valid            memory operation presented this cycle
//   i_alucode              ALU_* code; only the 8 load/store codes act
//   i_addr, i_wdata        effective address, store data
//   o_busy                 state not idle
//   o_done, o_fault        completion pulse, misalign/timeout flag
//   o_rdata                load result (0 for stores and faults)
//   o_mem_req/we/addr/wstrb/wdata, i_mem_ack, i_mem_rdata  memory port
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic [5:0]  i_alucode,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  // Load/store codes as defined for the core's ALU.
  localparam logic [5:0] ALU_LB  = 6'd18;
  localparam logic [5:0] ALU_LH  = 6'd19;
  localparam logic [5:0] ALU_LW  = 6'd20;
  localparam logic [5:0] ALU_LBU = 6'd21;
  localparam logic [5:0] ALU_LHU = 6'd22;
  localparam logic [5:0] ALU_SB  = 6'd23;
  localparam logic [5:0] ALU_SH  = 6'd24;
  localparam logic [5:0] ALU_SW  = 6'd25;

  // Counter holds the number of ack-less ACCESS cycles already elapsed.
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StErr} state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [5:0]  r_op, w_op_d;
  logic [1:0]  r_off, w_off_d;
  logic        r_busy, r_done, r_fault, r_mem_req, r_mem_we;
  logic [31:0] r_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        w_busy_d, w_done_d, w_fault_d, w_mem_req_d, w_mem_we_d;
  logic [31:0] w_rdata_d, w_mem_addr_d, w_mem_wdata_d;
  logic [3:0]  w_mem_wstrb_d;

  // Request decode.
  logic        w_is_ls, w_is_store, w_misaligned;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  always_comb begin
    w_is_ls      = 1'b0;
    w_is_store   = 1'b0;
    w_misaligned = 1'b0;
    w_wstrb      = 4'b0000;
    w_wdata      = 32'h0;
    case (i_alucode)
      ALU_LB, ALU_LBU: w_is_ls = 1'b1;
      ALU_LH, ALU_LHU: begin
        w_is_ls      = 1'b1;
        w_misaligned = i_addr[0];
      end
      ALU_LW: begin
        w_is_ls      = 1'b1;
        w_misaligned = |i_addr[1:0];
      end
      ALU_SB: begin
        w_is_ls    = 1'b1;
        w_is_store = 1'b1;
        w_wstrb    = 4'b0001 << i_addr[1:0];
        w_wdata    = {4{i_wdata[7:0]}};
      end
      ALU_SH: begin
        w_is_ls      = 1'b1;
        w_is_store   = 1'b1;
        w_misaligned = i_addr[0];
        w_wstrb      = 4'b0011 << i_addr[1:0];
        w_wdata      = {2{i_wdata[15:0]}};
      end
      ALU_SW: begin
        w_is_ls      = 1'b1;
        w_is_store   = 1'b1;
        w_misaligned = |i_addr[1:0];
        w_wstrb      = 4'b1111;
        w_wdata      = i_wdata;
      end
      default: ;
    endcase
  end

  // Load data extraction from the latched op and byte offset.
  logic [31:0] w_shifted, w_load;

  always_comb begin
    w_shifted = i_mem_rdata >> {r_off, 3'b000};
    w_load    = 32'h0;
    case (r_op)
      ALU_LB:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      ALU_LBU: w_load = {24'h0, w_shifted[7:0]};
      ALU_LH:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      ALU_LHU: w_load = {16'h0, w_shifted[15:0]};
      ALU_LW:  w_load = w_shifted;
      default: w_load = 32'h0;
    endcase
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_op_d        = r_op;
    w_off_d       = r_off;
    w_rdata_d     = 32'h0;
    w_mem_req_d   = r_mem_req;
    w_mem_we_d    = r_mem_we;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wstrb_d = r_mem_wstrb;
    w_mem_wdata_d = r_mem_wdata;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid && w_is_ls) begin
          if (w_misaligned) begin
            w_state_d = StErr;
          end else begin
            w_state_d     = StAccess;
            w_cnt_d       = 16'h0;
            w_op_d        = i_alucode;
            w_off_d       = i_addr[1:0];
            w_mem_req_d   = 1'b1;
            w_mem_we_d    = w_is_store;
            w_mem_addr_d  = {i_addr[31:2], 2'b00};
            w_mem_wstrb_d = w_wstrb;
            w_mem_wdata_d = w_wdata;
          end
        end
      end
      StAccess: begin
        // Ack takes priority over a timeout in the same cycle.
        if (i_mem_ack || (r_cnt == CntLast)) begin
          w_state_d     = i_mem_ack ? StResp : StErr;
          w_rdata_d     = i_mem_ack ? w_load : 32'h0;
          w_mem_req_d   = 1'b0;
          w_mem_we_d    = 1'b0;
          w_mem_addr_d  = 32'h0;
          w_mem_wstrb_d = 4'b0000;
          w_mem_wdata_d = 32'h0;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StResp:  w_state_d = StIdle;
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    w_busy_d  = (w_state_d != StIdle);
    w_done_d  = (w_state_d == StResp) || (w_state_d == StErr);
    w_fault_d = (w_state_d == StErr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= 16'h0;
      r_op        <= 6'h0;
      r_off       <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= 32'h0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wstrb <= 4'b0000;
      r_mem_wdata <= 32'h0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_op        <= w_op_d;
      r_off       <= w_off_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_fault     <= w_fault_d;
      r_rdata     <= w_rdata_d;
      r_mem_req   <= w_mem_req_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wstrb <= w_mem_wstrb_d;
      r_mem_wdata <= w_mem_wdata_d;
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_fault     = r_fault;
  assign o_rdata     = r_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wstrb = r_mem_wstrb;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed steps plus randomized operations, all checked
// against a byte-level reference model of the load/store rules.
module tb_lsu;

  localparam int unsigned T = 4;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd18;
  localparam logic [5:0] ALU_LH  = 6'd19;
  localparam logic [5:0] ALU_LW  = 6'd20;
  localparam logic [5:0] ALU_LBU = 6'd21;
  localparam logic [5:0] ALU_LHU = 6'd22;
  localparam logic [5:0] ALU_SB  = 6'd23;
  localparam logic [5:0] ALU_SH  = 6'd24;
  localparam logic [5:0] ALU_SW  = 6'd25;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [5:0]  alucode;
  logic [31:0] addr, wdata;
  logic        busy, done, fault;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(T)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_alucode   (alucode),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_fault     (fault),
    .o_rdata     (rdata),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wstrb (mem_wstrb),
    .o_mem_wdata (mem_wdata),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int size_of(input logic [5:0] c);
    if (c == ALU_LB || c == ALU_LBU || c == ALU_SB) return 1;
    if (c == ALU_LH || c == ALU_LHU || c == ALU_SH) return 2;
    return 4;
  endfunction

  function automatic bit is_store(input logic [5:0] c);
    return (c == ALU_SB || c == ALU_SH || c == ALU_SW);
  endfunction

  function automatic bit is_signed_load(input logic [5:0] c);
    return (c == ALU_LB || c == ALU_LH);
  endfunction

  task automatic chk_idle_outputs(input string name);
    chk({name, ".busy"},  busy,      32'd0);
    chk({name, ".done"},  done,      32'd0);
    chk({name, ".fault"}, fault,     32'd0);
    chk({name, ".rdata"}, rdata,     32'd0);
    chk({name, ".req"},   mem_req,   32'd0);
    chk({name, ".we"},    mem_we,    32'd0);
    chk({name, ".addr"},  mem_addr,  32'd0);
    chk({name, ".wstrb"}, mem_wstrb, 32'd0);
    chk({name, ".wdata"}, mem_wdata, 32'd0);
  endtask

  // One operation from acceptance to the first idle cycle. ack_k is the
  // cycle mem_ack is raised (0 = never). poke keeps req_valid high while busy.
  task automatic run_op(input string name, input logic [5:0] code, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_k, input logic [31:0] word,
                        input bit poke);
    int          sz, o, done_c, req_c;
    bit          mis, e_fault, st;
    logic [31:0] e_rd, e_wd, s;
    logic [3:0]  e_ws;
    longint      m, v;
    bit          in_acc;

    sz  = size_of(code);
    st  = is_store(code);
    o   = int'(a[1:0]);
    mis = (o % sz) != 0;
    if (mis) begin
      done_c = 1; req_c = 0; e_fault = 1'b1;
    end else if (ack_k >= 1 && ack_k <= int'(T)) begin
      done_c = ack_k + 1; req_c = ack_k; e_fault = 1'b0;
    end else begin
      done_c = int'(T) + 1; req_c = int'(T); e_fault = 1'b1;
    end

    e_ws = 4'b0000;
    e_wd = 32'h0;
    if (st) begin
      for (int i = 0; i < 4; i++) begin
        e_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
        if (i >= o && i < o + sz) e_ws[i] = 1'b1;
      end
    end

    e_rd = 32'h0;
    if (!st && !e_fault) begin
      s = word >> (8 * o);
      if (sz == 4) begin
        e_rd = s;
      end else begin
        m = longint'(1) << (8 * sz);
        v = longint'(s) % m;
        if (is_signed_load(code) && v >= m / 2) v = v - m;
        e_rd = 32'(v);
      end
    end

    req_valid = 1'b1;
    alucode   = code;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    alucode   = 6'($urandom);
    addr      = $urandom;
    wdata     = $urandom;

    for (int c = 1; c <= done_c + 1; c++) begin
      mem_ack   = (c == ack_k);
      mem_rdata = (c == ack_k) ? word : $urandom;
      if (poke) begin
        req_valid = (c <= done_c);
        alucode   = ALU_SW;
      end
      @(negedge clk);
      in_acc = (c <= req_c);
      chk($sformatf("%s.c%0d.req", name, c),   mem_req,   32'(in_acc));
      chk($sformatf("%s.c%0d.we", name, c),    mem_we,    32'(in_acc && st));
      chk($sformatf("%s.c%0d.addr", name, c),  mem_addr,  in_acc ? (a & ~32'h3) : 32'h0);
      chk($sformatf("%s.c%0d.wstrb", name, c), mem_wstrb, in_acc ? 32'(e_ws) : 32'h0);
      chk($sformatf("%s.c%0d.wdata", name, c), mem_wdata, in_acc ? e_wd : 32'h0);
      chk($sformatf("%s.c%0d.done", name, c),  done,      32'(c == done_c));
      chk($sformatf("%s.c%0d.fault", name, c), fault,     32'(c == done_c && e_fault));
      chk($sformatf("%s.c%0d.rdata", name, c), rdata,     (c == done_c) ? e_rd : 32'h0);
      chk($sformatf("%s.c%0d.busy", name, c),  busy,      32'(c <= done_c));
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      req_valid = 1'b0;
    end
  endtask

  initial begin
    logic [5:0]  codes [8];
    logic [5:0]  c;
    logic [31:0] a;
    int          sz;

    codes = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};
    rst       = 1'b1;
    req_valid = 1'b0;
    alucode   = 6'h0;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases.
    run_op("lb",     ALU_LB,  32'h0000_1003, 32'h0, 1, 32'h80FF_1234, 1'b0);
    run_op("lbu",    ALU_LBU, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234, 1'b0);
    run_op("sh",     ALU_SH,  32'h0000_2002, 32'hDEAD_BEEF, 3, 32'h0, 1'b0);
    run_op("mis_lw", ALU_LW,  32'h0000_3001, 32'h0, 0, 32'h0, 1'b0);
    run_op("mis_sh", ALU_SH,  32'h0000_3001, 32'h1234_5678, 0, 32'h0, 1'b0);
    run_op("sb",     ALU_SB,  32'h0000_3001, 32'h0000_00A5, 1, 32'h0, 1'b0);
    run_op("tmo",    ALU_LW,  32'h0000_0100, 32'h0, 0, 32'h0, 1'b0);
    run_op("ack_at_limit", ALU_LH, 32'h0000_0202, 32'h0, int'(T), 32'h8001_7FFE, 1'b0);
    run_op("busy_poke", ALU_LW, 32'h0000_0400, 32'h0, 2, 32'hCAFE_F00D, 1'b1);

    // Reset in cycle 2 of a store, before any ack.
    req_valid = 1'b1;
    alucode   = ALU_SW;
    addr      = 32'h0000_0040;
    wdata     = 32'h1122_3344;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst.c1.req", mem_req, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst.c3");
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst.c4.done", done, 32'd0);
    @(posedge clk);
    #1;
    run_op("post_rst_lw", ALU_LW, 32'h0000_0010, 32'h0, 1, 32'h0BAD_C0DE, 1'b0);

    // Non-load/store code is ignored.
    req_valid = 1'b1;
    alucode   = ALU_ADD;
    addr      = 32'h0000_0001;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk_idle_outputs("add.c1");
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle_outputs("add.c2");

    // Stray ack while idle.
    @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk_idle_outputs("stray_ack");
    @(posedge clk);
    #1;

    // Randomized operations, mostly aligned.
    for (int n = 0; n < 40; n++) begin
      c  = codes[$urandom_range(0, 7)];
      sz = size_of(c);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 4) a[1:0] = 2'b00;
        if (sz == 2) a[0] = 1'b0;
      end
      run_op($sformatf("rnd%0d", n), c, a, $urandom, int'($urandom_range(0, 6)), $urandom,
             1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the `alu` in the rv32i execute path. It takes the effective address computed by the ALU for `ALU_LB`…`ALU_SW`, checks alignment, and drives a single-outstanding request/acknowledge data-memory port. It returns sign- or zero-extended load data, or performs byte-lane-masked stores. While it works it holds `busy` high so the pipeline stalls.

## Interface
- `TIMEOUT`, 255: cycles to wait for `mem_ack` before aborting with a fault; range 1..65535.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute stage presents a memory operation this cycle.
- `alucode`  in  6  `ALU_*` code from define.vh; only the 8 load/store codes are acted on.
- `addr`  in  32  effective address (ALU `alu_result`).
- `wdata`  in  32  store data (rs2 value).
- `busy`  out  1  high whenever state ≠ IDLE; upstream must stall.
- `done`  out  1  one-cycle pulse, operation finished (success or fault).
- `fault`  out  1  valid with `done`: misaligned access or timeout.
- `rdata`  out  32  load result, valid with `done`; 0 for stores and faults.
- `mem_req`  out  1  memory request, held until `mem_ack` or timeout.
- `mem_we`  out  1  1 = store.
- `mem_addr`  out  32  word address, `{addr[31:2], 2'b00}`.
- `mem_wstrb`  out  4  byte-lane write enables; 0 on loads.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory completes the request (read data valid this cycle).
- `mem_rdata`  in  32  read word.

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE and the wait counter to 0.
- States are IDLE, ACCESS, RESP, and ERR.
- **IDLE**
  - `req_valid` with a non-load/store `alucode` is ignored.
  - For a load/store, alignment is checked:
    - `LW`/`SW` need `addr[1:0]==0`.
    - `LH`/`LHU`/`SH` need `addr[0]==0`.
    - Bytes are always aligned.
  - Misaligned: go to ERR. No memory access is made.
  - Aligned: latch `alucode` and `addr[1:0]`, drive the `mem_*` outputs, set `mem_req`, and go to ACCESS.
- **Store lanes** (`o` = `addr[1:0]`)
  - `SB`: `wstrb = 4'b0001<<o`, `wdata = {4{wdata[7:0]}}`.
  - `SH`: `wstrb = 4'b0011<<o`, `wdata = {2{wdata[15:0]}}`.
  - `SW`: `wstrb = 4'b1111`, `wdata` unchanged.
- **ACCESS**
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb` and `mem_wdata` are held stable.
  - Counter increments each cycle without ack.
  - On `mem_ack`:
    - Clear `mem_req`.
    - For loads, capture extracted data. Let `s = mem_rdata >> (8*o)`.
    - `LB`/`LH` sign-extend `s[7:0]`/`s[15:0]`.
    - `LBU`/`LHU` zero-extend them.
    - `LW` takes the full word.
    - Go to RESP.
  - If the counter reaches `TIMEOUT` with no ack: clear `mem_req` and go to ERR.
- **RESP**: `done=1`, `fault=0`, `rdata` valid, then go to IDLE.
- **ERR**: `done=1`, `fault=1`, `rdata=0`, then go to IDLE.
- `req_valid` while busy is ignored. `mem_ack` outside ACCESS is ignored.
- Reset mid-operation: the next edge forces IDLE and clears `mem_req`. No `done` is produced and the pending operation is discarded.

## Timing
- Request accepted at edge 0 (IDLE, `req_valid`). `mem_req` and `busy` are high from cycle 1.
- `mem_ack` in cycle k (k ≥ 1) gives `done` in cycle k+1 and `busy` low in cycle k+2. Zero-wait memory therefore gives latency 2.
- Misaligned: `done`+`fault` in cycle 1, `busy` low in cycle 2.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then `done`+`fault`.
- `mem_ack` in the same cycle the counter hits `TIMEOUT`: the ack wins (RESP, no fault).
- A new request can be accepted in the cycle `busy` is low, i.e. one cycle after `done`.

## Test plan
- **LB sign-extend:** `LB` at `addr=0x1003`, `mem_rdata=0x80FF_1234`, ack in cycle 1:
  - `mem_addr=0x1000`, `mem_we=0`, `mem_wstrb=0`.
  - `done` in cycle 2 with `rdata=0xFFFF_FF80`.
  - Repeat with `LBU`: `rdata=0x0000_0080`.
- **SH, 3 wait cycles:** `SH` at `addr=0x2002`, `wdata=0xDEAD_BEEF`, ack in cycle 3:
  - `mem_wstrb=4'b1100`, `mem_wdata=0xBEEF_BEEF`, held stable through cycles 1..3.
  - `done` in cycle 4, `rdata=0`.
- **Misaligned:**
  - `LW` at `0x3001`: `mem_req` never rises; `done=1`, `fault=1` in cycle 1.
  - `SH` at `0x3001`: same response.
  - `SB` at `0x3001`: proceeds normally.
- **Timeout:** `TIMEOUT=4`, `LW`, no ack: `mem_req` high cycles 1..4, `done`+`fault` in cycle 5, `busy` low in cycle 6.
- **Reset mid-access:** `SW` accepted, `rst` asserted in cycle 2 before ack:
  - Cycle 3: all outputs 0, state IDLE, no `done`.
  - A following `LW` at `0x10` with immediate ack completes normally.
- **Ignored inputs:**
  - `req_valid` with `ALU_ADD`: no state change.
  - `req_valid` pulsed while `busy`: no second `mem_req`.
  - Stray `mem_ack` in IDLE: no `done`.
